// File: rtl/alu_control_mdu_if.sv
// Bundle between EX-stage control and the ALU-control / multiply-divide unit.
// The master side presents the instruction; the slave side returns decode, hazard and HI/LO state.
interface alu_control_mdu_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       ALUOp;
    logic [5:0]       FuncCode;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [3:0]       out;
    logic             stall;
    logic [WIDTH-1:0] mdu_rdata;
    logic             mdu_sel;
    logic             busy;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, ALUOp, FuncCode, rs_data, rt_data,
        input  out, stall, mdu_rdata, mdu_sel, busy, illegal, hi, lo
    );

    modport slave (
        input  op_valid, ALUOp, FuncCode, rs_data, rt_data,
        output out, stall, mdu_rdata, mdu_sel, busy, illegal, hi, lo
    );
endinterface

// File: rtl/alu_control_mdu.sv
// ALU function decoder plus iterative radix-2 multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to include DIV/DIVU; without it the divider datapath is not built.
module alu_control_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    alu_control_mdu_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             a_neg_reg;
    logic             b_neg_reg;
`ifdef MDU_DIV_EN
    logic             div_reg;
`endif

    logic             rtype;
    logic             is_mul;
    logic             is_div;
    logic             is_hazard;
    logic             busy;
    logic             start;
    logic             do_mthi;
    logic             do_mtlo;
    logic             op_signed;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        bus.out     = 4'd0;
        bus.illegal = 1'b0;
        case (bus.ALUOp)
            2'b00:   bus.out = 4'd2;
            2'b01:   bus.out = 4'd6;
            default: begin
                case (bus.FuncCode)
                    F_ADD:   bus.out = 4'd2;
                    F_SUB:   bus.out = 4'd6;
                    F_AND:   bus.out = 4'd0;
                    F_OR:    bus.out = 4'd1;
                    F_NOR:   bus.out = 4'd12;
                    F_SLT:   bus.out = 4'd7;
                    F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO:
                             bus.out = 4'd2;
`ifdef MDU_DIV_EN
                    F_DIV, F_DIVU:
                             bus.out = 4'd2;
`endif
                    default: bus.illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign rtype  = bus.ALUOp[1];
    assign is_mul = (bus.FuncCode == F_MULT) || (bus.FuncCode == F_MULTU);
`ifdef MDU_DIV_EN
    assign is_div = (bus.FuncCode == F_DIV) || (bus.FuncCode == F_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign is_hazard = is_mul || is_div ||
                       (bus.FuncCode == F_MFHI) || (bus.FuncCode == F_MFLO) ||
                       (bus.FuncCode == F_MTHI) || (bus.FuncCode == F_MTLO);

    assign busy      = (state_reg != S_IDLE);
    assign bus.busy  = busy;
    assign bus.stall = bus.op_valid && rtype && busy && is_hazard;

    assign start   = bus.op_valid && rtype && (is_mul || is_div) && (state_reg == S_IDLE);
    assign do_mthi = bus.op_valid && rtype && (bus.FuncCode == F_MTHI) && (state_reg == S_IDLE);
    assign do_mtlo = bus.op_valid && rtype && (bus.FuncCode == F_MTLO) && (state_reg == S_IDLE);

    assign bus.mdu_rdata = (bus.FuncCode == F_MFHI) ? hi_reg :
                           (bus.FuncCode == F_MFLO) ? lo_reg : '0;
    assign bus.mdu_sel   = bus.op_valid && rtype && !bus.stall &&
                           ((bus.FuncCode == F_MFHI) || (bus.FuncCode == F_MFLO));
    assign bus.hi = hi_reg;
    assign bus.lo = lo_reg;

    // Signed variants have an even funct; the iteration itself only sees magnitudes.
    assign op_signed = ~bus.FuncCode[0];
    assign a_neg_c   = op_signed & bus.rs_data[WIDTH-1];
    assign b_neg_c   = op_signed & bus.rt_data[WIDTH-1];
    assign a_mag     = a_neg_c ? (-bus.rs_data) : bus.rs_data;
    assign b_mag     = b_neg_c ? (-bus.rt_data) : bus.rt_data;

    assign mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
    assign prod     = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = (a_neg_reg ^ b_neg_reg) ? (-prod) : prod;

`ifdef MDU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_reg};
    assign div_ok    = ~div_diff[WIDTH];
    // A zero divisor leaves the remainder holding |dividend|, so the sign fix restores it exactly.
    assign quo_fix   = (opb_reg == '0) ? '1 :
                       ((a_neg_reg ^ b_neg_reg) ? (-acc_lo_reg) : acc_lo_reg);
    assign rem_fix   = a_neg_reg ? (-acc_hi_reg) : acc_hi_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
`ifdef MDU_DIV_EN
            div_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        acc_hi_reg <= '0;
                        acc_lo_reg <= a_mag;
                        opb_reg    <= b_mag;
                        a_neg_reg  <= a_neg_c;
                        b_neg_reg  <= b_neg_c;
`ifdef MDU_DIV_EN
                        div_reg    <= is_div;
`endif
                        cnt_reg    <= '0;
                        state_reg  <= S_RUN;
                    end else begin
                        if (do_mthi) hi_reg <= bus.rs_data;
                        if (do_mtlo) lo_reg <= bus.rs_data;
                    end
                end
                S_RUN: begin
`ifdef MDU_DIV_EN
                    if (div_reg) begin
                        acc_hi_reg <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ok};
                    end else
`endif
                    begin
                        acc_hi_reg <= mul_sum[WIDTH:1];
                        acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) state_reg <= S_FIX;
                end
                S_FIX: begin
`ifdef MDU_DIV_EN
                    if (div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else
`endif
                    begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_mdu.sv
// Randomised self-checking bench for alu_control_mdu against an arithmetic reference model.
module tb_alu_control_mdu;
    localparam int WIDTH = 32;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_control_mdu_if #(.WIDTH(WIDTH)) bus ();
    alu_control_mdu #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    function automatic logic [4:0] ref_dec(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b00) return {1'b0, 4'd2};
        if (aop == 2'b01) return {1'b0, 4'd6};
        case (f)
            6'b100000: return {1'b0, 4'd2};
            6'b100010: return {1'b0, 4'd6};
            6'b100100: return {1'b0, 4'd0};
            6'b100101: return {1'b0, 4'd1};
            6'b100111: return {1'b0, 4'd12};
            6'b101010: return {1'b0, 4'd7};
            F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO: return {1'b0, 4'd2};
`ifdef MDU_DIV_EN
            F_DIV, F_DIVU: return {1'b0, 4'd2};
`endif
            default: return {1'b1, 4'd0};
        endcase
    endfunction

    // Returns {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            F_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            F_MULTU: return {32'h0, a} * {32'h0, b};
            F_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            F_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.ALUOp    = aop;
        bus.FuncCode = f;
        bus.rs_data  = a;
        bus.rt_data  = b;
    endtask

    task automatic do_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int cyc;
        exp = ref_mdu(f, a, b);
        @(negedge clk);
        drive(1'b1, 2'b10, f, a, b);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL issue_stall f=%b got %b want 0", f, bus.stall);
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != WIDTH + 1) begin
            n_bad++;
            $display("FAIL busy_cycles f=%b got %0d want %0d", f, cyc, WIDTH + 1);
        end
        n_cmp++;
        if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
            n_bad++;
            $display("FAIL mdu_result f=%b a=%h b=%h got %h_%h want %h_%h",
                     f, a, b, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        $display("mdu f=%b a=%h b=%h hi=%h lo=%h cycles=%0d", f, a, b, bus.hi, bus.lo, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 2'b10, F_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl busy=%b stall=%b want 0 0", bus.busy, bus.stall);
        end
        n_cmp++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hilo got %h_%h want 0_0", bus.hi, bus.lo);
        end
        $display("reset busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
    endtask

    task automatic test_decode();
        logic [5:0] tbl [7];
        logic [4:0] exp;
        logic [1:0] aop;
        logic [5:0] f;
        tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000001};
        for (int i = 0; i < 47; i++) begin
            @(negedge clk);
            if (i < 7) begin
                aop = 2'b10; f = tbl[i];
                drive(1'b1, aop, f, $urandom, $urandom);
            end else if (i < 9) begin
                aop = 2'(i - 7); f = 6'($urandom);
                drive(1'b1, aop, f, $urandom, $urandom);
            end else begin
                aop = 2'($urandom); f = 6'($urandom);
                drive(1'b0, aop, f, $urandom, $urandom);
            end
            exp = ref_dec(aop, f);
            #1;
            n_cmp++;
            if (bus.out !== exp[3:0] || bus.illegal !== exp[4]) begin
                n_bad++;
                $display("FAIL decode aop=%b f=%b got out=%0d ill=%b want out=%0d ill=%b",
                         aop, f, bus.out, bus.illegal, exp[3:0], exp[4]);
            end
            $display("decode aop=%b f=%b out=%0d ill=%b", aop, f, bus.out, bus.illegal);
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
    endtask

    task automatic test_mult();
        do_mdu(F_MULT, 32'd7, 32'hFFFFFFFD);
        do_mdu(F_MULTU, 32'd7, 32'hFFFFFFFD);
    endtask

    task automatic test_div();
`ifdef MDU_DIV_EN
        do_mdu(F_DIVU, 32'd100, 32'd7);
        do_mdu(F_DIV, 32'hFFFFFFF9, 32'd2);
        do_mdu(F_DIVU, 32'd5, 32'd0);
        do_mdu(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        do_mdu(F_DIV, 32'hFFFFFFF0, 32'd0);
`else
        @(negedge clk);
        drive(1'b1, 2'b10, F_DIVU, 32'd100, 32'd7);
        #1;
        n_cmp++;
        if (bus.illegal !== 1'b1 || bus.out !== 4'd0 || bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL div_disabled ill=%b out=%0d stall=%b want 1 0 0",
                     bus.illegal, bus.out, bus.stall);
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL div_no_start busy got %b want 0", bus.busy);
        end
        $display("divu disabled ill=%b busy=%b", bus.illegal, bus.busy);
`endif
    endtask

    task automatic test_hazard();
        logic [63:0] exp;
        logic [31:0] mt_val;
        logic [31:0] prev_lo;
        logic lo_moved;
        int cyc;
        exp = ref_mdu(F_MULT, 32'h1234, 32'hFFFF0001);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULT, 32'h1234, 32'hFFFF0001);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MFLO, 32'h0, 32'h0);
        cyc = 0;
        while (cyc < 100) begin
            #1;
            if (bus.stall !== 1'b1) break;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != WIDTH + 1) begin
            n_bad++;
            $display("FAIL mflo_stall_cycles got %0d want %0d", cyc, WIDTH + 1);
        end
        n_cmp++;
        if (bus.mdu_sel !== 1'b1 || bus.mdu_rdata !== exp[31:0]) begin
            n_bad++;
            $display("FAIL mflo_read sel=%b data=%h want 1 %h", bus.mdu_sel, bus.mdu_rdata, exp[31:0]);
        end
        $display("mflo after mult stall_cycles=%0d data=%h", cyc, bus.mdu_rdata);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        prev_lo = m_lo;

        exp = ref_mdu(F_MULTU, 32'hDEADBEEF, 32'h00C0FFEE);
        mt_val = $urandom;
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULTU, 32'hDEADBEEF, 32'h00C0FFEE);
        @(negedge clk);
        drive(1'b1, 2'b10, F_ADD, 32'h1, 32'h2);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.out !== 4'd2 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL add_in_busy stall=%b out=%0d busy=%b want 0 2 1", bus.stall, bus.out, bus.busy);
        end
        $display("add during busy stall=%b out=%0d", bus.stall, bus.out);
`ifndef MDU_DIV_EN
        @(negedge clk);
        drive(1'b1, 2'b10, F_DIV, 32'h9, 32'h3);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL div_in_busy stall=%b ill=%b want 0 1", bus.stall, bus.illegal);
        end
`endif
        @(negedge clk);
        drive(1'b1, 2'b10, F_MTLO, mt_val, 32'h0);
        lo_moved = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            #1;
            if (bus.stall !== 1'b1) break;
            if (bus.lo !== prev_lo) lo_moved = 1'b1;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (lo_moved !== 1'b0 || bus.lo !== exp[31:0]) begin
            n_bad++;
            $display("FAIL mtlo_busy moved=%b lo=%h want 0 %h", lo_moved, bus.lo, exp[31:0]);
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        n_cmp++;
        if (bus.lo !== mt_val || bus.hi !== exp[63:32]) begin
            n_bad++;
            $display("FAIL mtlo_after hi=%h lo=%h want %h %h", bus.hi, bus.lo, exp[63:32], mt_val);
        end
        m_hi = exp[63:32];
        m_lo = mt_val;
        $display("mtlo while busy stall_cycles=%0d lo=%h", cyc, bus.lo);
    endtask

    task automatic test_moves();
        logic [31:0] v;
        @(negedge clk);
        drive(1'b1, 2'b10, F_MTHI, 32'h12345678, 32'h0);
        #1;
        n_cmp++;
        if (bus.hi !== m_hi || bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL mthi_before hi=%h stall=%b want %h 0", bus.hi, bus.stall, m_hi);
        end
        @(negedge clk);
        drive(1'b1, 2'b10, F_MFHI, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if (bus.hi !== 32'h12345678 || bus.mdu_sel !== 1'b1 || bus.mdu_rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL mthi_mfhi hi=%h sel=%b data=%h want 12345678 1 12345678",
                     bus.hi, bus.mdu_sel, bus.mdu_rdata);
        end
        m_hi = 32'h12345678;
        $display("mthi hi=%h", bus.hi);
        v = $urandom;
        @(negedge clk);
        drive(1'b1, 2'b10, F_MTLO, v, 32'h0);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MFLO, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if (bus.mdu_rdata !== v || bus.mdu_sel !== 1'b1 || bus.hi !== m_hi) begin
            n_bad++;
            $display("FAIL mtlo_mflo data=%h sel=%b hi=%h want %h 1 %h", bus.mdu_rdata, bus.mdu_sel, bus.hi, v, m_hi);
        end
        m_lo = v;
        $display("mtlo lo=%h", bus.lo);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULTU, $urandom, $urandom);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        $display("reset mid-run busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        do_mdu(F_MULT, 32'd3, 32'd4);
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1;
        logic [63:0] e2;
        logic [31:0] a1, b1, a2, b2;
        int cyc;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = ref_mdu(F_MULT, a1, b1);
        e2 = ref_mdu(F_MULTU, a2, b2);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULT, a1, b1);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULTU, a2, b2);
        cyc = 0;
        while (cyc < 100) begin
            #1;
            if (bus.stall !== 1'b1) break;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != WIDTH + 1 || bus.hi !== e1[63:32] || bus.lo !== e1[31:0]) begin
            n_bad++;
            $display("FAIL b2b_first cycles=%0d got %h_%h want %0d %h_%h",
                     cyc, bus.hi, bus.lo, WIDTH + 1, e1[63:32], e1[31:0]);
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != WIDTH + 1 || bus.hi !== e2[63:32] || bus.lo !== e2[31:0]) begin
            n_bad++;
            $display("FAIL b2b_second cycles=%0d got %h_%h want %0d %h_%h",
                     cyc, bus.hi, bus.lo, WIDTH + 1, e2[63:32], e2[31:0]);
        end
        m_hi = e2[63:32];
        m_lo = e2[31:0];
        $display("back-to-back hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_random_mdu();
        logic [5:0] ops [$];
        logic [5:0] f;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{F_MULT, F_MULTU};
`ifdef MDU_DIV_EN
        ops.push_back(F_DIV);
        ops.push_back(F_DIVU);
`endif
        for (int i = 0; i < 10; i++) begin
            f = ops[$urandom_range(0, ops.size() - 1)];
            a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            do_mdu(f, a, b);
        end
    endtask

    initial begin
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_hazard();
        test_moves();
        test_reset_mid();
        test_back_to_back();
        test_random_mdu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Parametrised successor to the single-cycle ALU function decoder.
- Decodes ALUOp/FuncCode into the 4-bit ALU control code and sequences an iterative multiply/divide unit with HI/LO registers.
- Stalls the pipeline on MDU hazards.
- Sits in EX between the main control unit and the ALU/register write-back mux.

Parameters:
- WIDTH, 32, datapath width of operands, HI, LO (must be >= 4, even).
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  instruction in EX is valid this cycle.
- ALUOp  input  2  from main control: 00 add, 01 sub, 10 R-type, 11 reserved (treated as R-type).
- FuncCode  input  6  R-type funct field.
- rs_data  input  WIDTH  operand A / dividend / MTHI-MTLO source.
- rt_data  input  WIDTH  operand B / divisor.
- out  output  4  ALU control code.
- stall  output  1  hold IF/ID/EX this cycle.
- mdu_rdata  output  WIDTH  MFHI/MFLO read data.
- mdu_sel  output  1  write-back takes mdu_rdata instead of ALU result.
- busy  output  1  MDU iterating.
- illegal  output  1  R-type funct not recognised.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Decode of `out` (combinational; independent of op_valid):
  - ALUOp 00 -> 2.
  - ALUOp 01 -> 6.
  - R-type funct map: 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 100111 -> 12, 101010 -> 7.
  - MDU functs (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011) -> out = 2, illegal = 0.
  - Any other funct -> out = 0, illegal = 1.
- Reset values: state IDLE; hi = lo = 0; busy = 0; counter = 0. With reset asserted, stall = 0.
- FSM states:
  - IDLE: busy = 0.
    - op_valid & R-type & MULT/MULTU/DIV/DIVU: capture operands and kind; counter = 0; go to RUN.
    - MTHI/MTLO: write rs_data to hi/lo at this edge; stay IDLE.
  - RUN: busy = 1. One radix-2 step per cycle on magnitudes:
    - Multiply: shift-add.
    - Divide: restoring.
    - Signed ops take absolute values at capture.
    - After WIDTH steps (counter == WIDTH-1 at the edge), go to FIX.
  - FIX: busy = 1.
    - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
    - Write hi/lo; go to IDLE.
- Latency: accept edge E0; hi/lo valid after edge E(WIDTH+1), i.e. 33 cycles for WIDTH = 32. Back-to-back MDU ops have a 1-cycle IDLE minimum.
- Divide by zero (divisor == 0): runs full latency; lo = all ones, hi = dividend (rs_data as captured, unsigned).
- Overflow (signed most-negative / -1): lo = most-negative, hi = 0. No trap.
- stall = op_valid & R-type & busy & funct ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}. A stalled op is re-presented; nothing is captured while stalled.
- mdu_rdata = hi when funct = MFHI, lo when MFLO, else 0. mdu_sel = op_valid & R-type & (MFHI | MFLO) & ~stall.
- Simultaneous cases:
  - Issue in the FIX cycle is stalled.
  - In the IDLE cycle after FIX, MFLO reads the new lo.
- Reset mid-operation: immediate abort to IDLE, hi/lo cleared, no partial write.
- Non-MDU ops never stall and are unaffected by busy.

Optional Feature:
- Macro: MDU_DIV_EN.
- Defined: DIV/DIVU supported as above.
- Undefined:
  - DIV/DIVU decode as illegal = 1, out = 0, never start the FSM and never stall.
  - Divider datapath not synthesised; MULT/MULTU and all moves unchanged.

Test Plan (WIDTH = 32):
- ALUOp 10, each of the six ALU functs, plus funct 000001 -> out 2, 6, 0, 1, 12, 7, then 0 with illegal = 1. ALUOp 00 -> 2; ALUOp 01 -> 6.
- MULT rs = 7, rt = 0xFFFFFFFD -> busy for 33 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULTU same operands -> hi = 0x00000006, lo = 0xFFFFFFEB.
- DIVU 100 / 7 -> lo = 14, hi = 2. DIV 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 5 / 0 -> lo = 0xFFFFFFFF, hi = 5.
- MFLO issued 1 cycle after MULT: stall high exactly until the cycle after FIX, then mdu_sel = 1 with the new lo. An ADD issued during busy -> no stall.
- MTHI 0x12345678 in IDLE -> hi updates at the next edge. MTLO while busy -> stalled, lo unchanged until completion.
- Assert reset at RUN cycle 10 -> busy = 0, hi = lo = 0 asynchronously. Next MULT 3 * 4 after release -> lo = 12.
